systolic_gemm_core: RTL and testbench
=====================================

// Module: systolic_gemm_core
// PURPOSE
// - Parametrised output-stationary systolic matrix-multiply core; successor to the fixed 8-bit PE grid.
// - Adds input skew, a start/done control FSM, stall-tolerant valid/ready streaming, signed/unsigned mode and row-by-row result drain.
// - Sits between the operand streamer (A/W vectors per beat) and the result writeback; computes C[i][j] = sum_k A[k][i]*W[k][j].
// PARAMETERS
// - ROWS    4   PE rows; activation vector length
// - COLS    4   PE columns; weight vector length
// - DW      8   operand width
// - AW      32  accumulator width, must be >= 2*DW
// - KW      16  width of k_len; max K = 2^KW-1
// PORTS
// - clk          in   1          clock
// - rstn         in   1          asynchronous active-low reset
// - start        in   1          begin job; sampled only in IDLE
// - k_len        in   KW         reduction length K, sampled with start
// - signed_mode  in   1          1: operands two's complement; sampled with start
// - in_valid     in   1          operand beat valid
// - in_ready     out  1          core accepts a beat
// - in_a         in   ROWS*DW    A[k][i] at bits [DW*i +: DW]
// - in_w         in   COLS*DW    W[k][j] at bits [DW*j +: DW]
// - out_valid    out  1          result row valid
// - out_ready    in   1          writeback accepts row
// - out_row      out  clog2(ROWS) row index of out_data (min width 1)
// - out_data     out  COLS*AW    C[out_row][j] at bits [AW*j +: AW]
// - busy         out  1          high in any state but IDLE
// - done         out  1          one-cycle pulse after last row drained
// BEHAVIOUR
// - Reset (async, any state): FSM->IDLE; all skew regs, PE pipes, accumulators, counters = 0; in_ready, out_valid, busy, done = 0; out_row, out_data = 0.
// - States: IDLE -> LOAD -> FLUSH -> DRAIN -> IDLE.
// - IDLE: start=1 latches k_len/signed_mode, clears all accumulators, goes to LOAD (k_len=0: straight to DRAIN, results all zero).
// - start while busy ignored; no abort other than rstn.
// - LOAD: in_ready=1. Beat accepted when in_valid&in_ready; array advances one step only on accepted beats (stall freezes all skew regs, PE pipes, accumulators).
// - After K accepted beats -> FLUSH, in_ready=0 from next cycle.
// - Skew: row i activation delayed i advances, column j weight delayed j advances. A moves right, W moves down, one PE per advance.
// - FLUSH: array advances every cycle injecting zeros for exactly ROWS+COLS-1 cycles, then DRAIN.
// - Each PE: acc += a*w on every advance with DW x DW product sign- or zero-extended per latched signed_mode.
// - Accumulation wraps modulo 2^AW, no saturation.
// - DRAIN: out_valid=1, out_row counts 0..ROWS-1, advancing only on out_valid&out_ready.
// - out_data stable while out_valid&!out_ready.
// - After row ROWS-1 handshake: out_valid=0, done=1 for one cycle, state IDLE.
// - A new start is accepted in the cycle after done.
// - Latency, no stalls: first out_valid K+ROWS+COLS-1 cycles after the first accepted beat.
// STRUCTURE
// - Shared package systola_pkg: state enum (IDLE/LOAD/FLUSH/DRAIN), clog2 helper, packing macros for DW/AW vectors.
// - Sub-module pe_mac: one PE holding the a/w forward regs and the AW accumulator, with advance enable, clear and signed_mode inputs.
// - Instantiate pe_mac ROWS*COLS times in generate loops.
// - Skew shift registers, FSM and counters live in this module.
// TESTING
// - 2x2, DW=8, K=1, A=[1,2], W=[3,4] -> rows [3,4],[6,8], done pulse once.
// - 4x4 signed, K=2, all A=-1, all W=127 -> every C = -254.
// - Same data unsigned -> every C = 255*127*2 = 64770.
// - in_valid toggled 1/0 each cycle, K=4 -> results equal the no-stall run.
// - out_ready held low 5 cycles on row 1 -> out_data/out_row stable, no row skipped.
// - k_len=0 -> ROWS zero rows, then done.
// - rstn low mid-FLUSH -> all outputs 0 immediately; next job correct.
// - AW=16, DW=8 unsigned, K=2, all A=W=255 -> C = 130050 mod 65536 = 64514 (wrap).

Source files
------------

// File: rtl/systola_pkg.sv
// Shared types and helpers for the systolic GEMM core: controller states,
// a width helper and a vector slice macro.
`ifndef SYSTOLA_PKG_SV
`define SYSTOLA_PKG_SV

`define SYSTOLA_SLICE(vec, w, idx) vec[(w)*(idx) +: (w)]

package systola_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // Width of an index over n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`endif

// File: rtl/systolic_gemm_core_pe_mac.sv
// One processing element: forwards A right and W down, and accumulates
// their product on every array advance.
module pe_mac #(
    parameter int DW = 8,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          adv_i,
    input  logic          clr_i,
    input  logic          signed_mode_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] w_i,
    output logic [DW-1:0] a_o,
    output logic [DW-1:0] w_o,
    output logic [AW-1:0] acc_o
);

    logic [DW-1:0] a_q;
    logic [DW-1:0] w_q;
    logic [AW-1:0] acc_q;
    logic [AW-1:0] a_x;
    logic [AW-1:0] w_x;
    logic [AW-1:0] prod;

    // Extending both operands to AW makes the AW-bit product exact modulo 2^AW.
    assign a_x  = {{(AW-DW){signed_mode_i & a_i[DW-1]}}, a_i};
    assign w_x  = {{(AW-DW){signed_mode_i & w_i[DW-1]}}, w_i};
    assign prod = a_x * w_x;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_q   <= '0;
            w_q   <= '0;
            acc_q <= '0;
        end else if (clr_i) begin
            a_q   <= '0;
            w_q   <= '0;
            acc_q <= '0;
        end else if (adv_i) begin
            a_q   <= a_i;
            w_q   <= w_i;
            acc_q <= acc_q + prod;
        end
    end

    assign a_o   = a_q;
    assign w_o   = w_q;
    assign acc_o = acc_q;

endmodule

// File: rtl/systolic_gemm_core.sv
// Output-stationary systolic GEMM core: operand skew, control FSM and row drain.
//   state | meaning
//   IDLE  | waiting for start
//   LOAD  | accepting K operand beats
//   FLUSH | advancing with zero injection until the last products land
//   DRAIN | presenting result rows 0..ROWS-1
module systolic_gemm_core
    import systola_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int DW   = 8,
    parameter int AW   = 32,
    parameter int KW   = 16,
    localparam int RW  = clog2_min1(ROWS)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic [KW-1:0]      k_len,
    input  logic               signed_mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ROWS*DW-1:0] in_a,
    input  logic [COLS*DW-1:0] in_w,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [RW-1:0]      out_row,
    output logic [COLS*AW-1:0] out_data,
    output logic               busy,
    output logic               done
);

    localparam int FW = $clog2(ROWS + COLS) + 1;
    localparam logic [FW-1:0] FLUSH_N = FW'(ROWS + COLS - 1);

    state_e        state_q, state_d;
    logic [KW-1:0] k_cnt_q, k_cnt_d;
    logic [FW-1:0] fl_cnt_q, fl_cnt_d;
    logic [RW-1:0] row_q, row_d;
    logic          smode_q, smode_d;
    logic          done_q, done_d;
    logic          adv;
    logic          clr;

    logic [DW-1:0] a_h [ROWS][COLS+1];
    logic [DW-1:0] w_v [ROWS+1][COLS];
    logic [AW-1:0] acc [ROWS][COLS];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            k_cnt_q  <= '0;
            fl_cnt_q <= '0;
            row_q    <= '0;
            smode_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_cnt_q  <= k_cnt_d;
            fl_cnt_q <= fl_cnt_d;
            row_q    <= row_d;
            smode_q  <= smode_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_cnt_d   = k_cnt_q;
        fl_cnt_d  = fl_cnt_q;
        row_d     = row_q;
        smode_d   = smode_q;
        done_d    = 1'b0;
        adv       = 1'b0;
        clr       = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    smode_d  = signed_mode;
                    k_cnt_d  = k_len;
                    fl_cnt_d = FLUSH_N;
                    row_d    = '0;
                    clr      = 1'b1;
                    state_d  = (k_len == '0) ? DRAIN : LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    adv     = 1'b1;
                    k_cnt_d = k_cnt_q - 1'b1;
                    if (k_cnt_q == KW'(1)) state_d = FLUSH;
                end
            end
            FLUSH: begin
                adv      = 1'b1;
                fl_cnt_d = fl_cnt_q - 1'b1;
                if (fl_cnt_q == FW'(1)) state_d = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (row_q == RW'(ROWS - 1)) begin
                        row_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Row i of A is delayed by i advances; outside LOAD zeros are injected.
    for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
        logic [DW-1:0] a_src;
        logic          unused_a_edge;
        assign a_src         = (state_q == LOAD) ? `SYSTOLA_SLICE(in_a, DW, i) : '0;
        assign unused_a_edge = ^a_h[i][COLS];
        if (i == 0) begin : g_direct
            assign a_h[i][0] = a_src;
        end else begin : g_delay
            logic [DW-1:0] sk_q [i];
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int s = 0; s < i; s++) sk_q[s] <= '0;
                end else if (clr) begin
                    for (int s = 0; s < i; s++) sk_q[s] <= '0;
                end else if (adv) begin
                    sk_q[0] <= a_src;
                    for (int s = 1; s < i; s++) sk_q[s] <= sk_q[s-1];
                end
            end
            assign a_h[i][0] = sk_q[i-1];
        end
    end

    for (genvar j = 0; j < COLS; j++) begin : g_w_skew
        logic [DW-1:0] w_src;
        logic          unused_w_edge;
        assign w_src         = (state_q == LOAD) ? `SYSTOLA_SLICE(in_w, DW, j) : '0;
        assign unused_w_edge = ^w_v[ROWS][j];
        if (j == 0) begin : g_direct
            assign w_v[0][j] = w_src;
        end else begin : g_delay
            logic [DW-1:0] sk_q [j];
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int s = 0; s < j; s++) sk_q[s] <= '0;
                end else if (clr) begin
                    for (int s = 0; s < j; s++) sk_q[s] <= '0;
                end else if (adv) begin
                    sk_q[0] <= w_src;
                    for (int s = 1; s < j; s++) sk_q[s] <= sk_q[s-1];
                end
            end
            assign w_v[0][j] = sk_q[j-1];
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            pe_mac #(.DW(DW), .AW(AW)) u_pe (
                .clk          (clk),
                .rstn         (rstn),
                .adv_i        (adv),
                .clr_i        (clr),
                .signed_mode_i(smode_q),
                .a_i          (a_h[i][j]),
                .w_i          (w_v[i][j]),
                .a_o          (a_h[i][j+1]),
                .w_o          (w_v[i+1][j]),
                .acc_o        (acc[i][j])
            );
        end
    end

    always_comb begin
        out_data = '0;
        for (int j = 0; j < COLS; j++) begin
            `SYSTOLA_SLICE(out_data, AW, j) = acc[row_q][j];
        end
    end

    assign out_row = row_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;

endmodule

// File: tb/tb_systolic_gemm_core.sv
// Directed bench: a 4x4/AW=32 core for the main jobs and a 2x2/AW=16 core for
// the small-matrix and accumulator-wrap cases.
module tb_systolic_gemm_core;

    localparam int R  = 4;
    localparam int C  = 4;
    localparam int DW = 8;
    localparam int AW = 32;
    localparam int KW = 16;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic              start, signed_mode, in_valid, in_ready, out_valid, out_ready, busy, done;
    logic [KW-1:0]     k_len;
    logic [R*DW-1:0]   in_a;
    logic [C*DW-1:0]   in_w;
    logic [1:0]        out_row;
    logic [C*AW-1:0]   out_data;

    logic              s_start, s_sm, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy, s_done;
    logic [KW-1:0]     s_k_len;
    logic [15:0]       s_in_a, s_in_w;
    logic [0:0]        s_out_row;
    logic [31:0]       s_out_data;

    systolic_gemm_core #(.ROWS(R), .COLS(C), .DW(DW), .AW(AW), .KW(KW)) u_dut (
        .clk(clk), .rstn(rstn), .start(start), .k_len(k_len), .signed_mode(signed_mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_w(in_w),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_data(out_data),
        .busy(busy), .done(done)
    );

    systolic_gemm_core #(.ROWS(2), .COLS(2), .DW(8), .AW(16), .KW(KW)) u_small (
        .clk(clk), .rstn(rstn), .start(s_start), .k_len(s_k_len), .signed_mode(s_sm),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_a(s_in_a), .in_w(s_in_w),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_row(s_out_row), .out_data(s_out_data),
        .busy(s_busy), .done(s_done)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int          a_t [16][R];
    int          w_t [16][C];
    logic [31:0] exp_c [R][C];

    function automatic int sx(input int v, input bit sm);
        logic [7:0] b;
        b = v[7:0];
        return sm ? int'($signed(b)) : int'(b);
    endfunction

    task automatic model(input int k, input bit sm);
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) begin
                logic [31:0] acc;
                acc = '0;
                for (int kk = 0; kk < k; kk++) acc += 32'(sx(a_t[kk][i], sm) * sx(w_t[kk][j], sm));
                exp_c[i][j] = acc;
            end
    endtask

    task automatic fill(input int k, input int av, input int wv, input logic [31:0] cv);
        for (int kk = 0; kk < k; kk++) begin
            for (int i = 0; i < R; i++) a_t[kk][i] = av;
            for (int j = 0; j < C; j++) w_t[kk][j] = wv;
        end
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) exp_c[i][j] = cv;
    endtask

    task automatic fill_mixed(input int k);
        for (int kk = 0; kk < k; kk++) begin
            for (int i = 0; i < R; i++) a_t[kk][i] = 3 * kk + i + 1;
            for (int j = 0; j < C; j++) w_t[kk][j] = 2 * j + 5 - kk;
        end
    endtask

    function automatic logic [127:0] exp_row(input int r);
        logic [127:0] v;
        v = '0;
        for (int j = 0; j < C; j++) v[32*j +: 32] = exp_c[r][j];
        return v;
    endfunction

    task automatic start_job(input int k, input bit sm);
        @(negedge clk);
        start = 1'b1; k_len = KW'(k); signed_mode = sm;
        @(negedge clk);
        start = 1'b0; k_len = '0; signed_mode = 1'b0;
    endtask

    task automatic feed(input int k, input bit toggle, output int first_cyc);
        int sent, guard;
        sent = 0; guard = 0; first_cyc = -1;
        while (sent < k && guard < 200) begin
            in_valid = toggle ? (guard % 2 == 0) : 1'b1;
            for (int i = 0; i < R; i++) in_a[DW*i +: DW] = 8'(a_t[sent][i]);
            for (int j = 0; j < C; j++) in_w[DW*j +: DW] = 8'(w_t[sent][j]);
            if (in_valid && in_ready) begin
                if (sent == 0) first_cyc = cyc;
                sent++;
            end
            guard++;
            @(negedge clk);
        end
        in_valid = 1'b0; in_a = '0; in_w = '0;
        check_eq("beats_accepted", 128'(sent), 128'(k));
        check_eq("in_ready_after_load", in_ready, 1'b0);
        check_eq("busy_after_load", busy, 1'b1);
    endtask

    task automatic collect(input int k, input int first_cyc, input bit chk_lat, input int hold_row);
        int guard;
        guard = 0;
        while (!out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_eq("drain_reached", out_valid, 1'b1);
        if (chk_lat) check_eq("first_valid_latency", 128'(cyc - first_cyc), 128'(k + R + C - 1));
        for (int r = 0; r < R; r++) begin
            check_eq("row_index", 128'(out_row), 128'(r));
            check_eq("row_data", out_data, exp_row(r));
            if (r == hold_row) begin
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check_eq("stall_valid", out_valid, 1'b1);
                    check_eq("stall_row", 128'(out_row), 128'(r));
                    check_eq("stall_data", out_data, exp_row(r));
                end
            end
            out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        check_eq("done_pulse", done, 1'b1);
        check_eq("valid_after_drain", out_valid, 1'b0);
        check_eq("idle_after_drain", busy, 1'b0);
        @(negedge clk);
        check_eq("done_one_cycle", done, 1'b0);
    endtask

    task automatic s_run(input int k, input logic [15:0] a0, input logic [15:0] w0,
                         input logic [15:0] a1, input logic [15:0] w1,
                         input logic [31:0] r0, input logic [31:0] r1);
        int guard, dn;
        @(negedge clk);
        s_start = 1'b1; s_k_len = KW'(k); s_sm = 1'b0;
        @(negedge clk);
        s_start = 1'b0;
        for (int b = 0; b < k; b++) begin
            s_in_valid = 1'b1;
            s_in_a = (b == 0) ? a0 : a1;
            s_in_w = (b == 0) ? w0 : w1;
            check_eq("s_in_ready", s_in_ready, 1'b1);
            @(negedge clk);
        end
        s_in_valid = 1'b0;
        guard = 0;
        while (!s_out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_eq("s_drain_reached", s_out_valid, 1'b1);
        check_eq("s_row0_index", s_out_row, 1'b0);
        check_eq("s_row0_data", s_out_data, r0);
        s_out_ready = 1'b1;
        @(negedge clk);
        check_eq("s_row1_index", s_out_row, 1'b1);
        check_eq("s_row1_data", s_out_data, r1);
        @(negedge clk);
        s_out_ready = 1'b0;
        dn = int'(s_done);
        repeat (4) begin
            @(negedge clk);
            dn += int'(s_done);
        end
        check_eq("s_done_count", 128'(dn), 128'd1);
        check_eq("s_idle", s_busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fc;
        rstn = 1'b0;
        start = 0; k_len = '0; signed_mode = 0; in_valid = 0; in_a = '0; in_w = '0; out_ready = 0;
        s_start = 0; s_k_len = '0; s_sm = 0; s_in_valid = 0; s_in_a = '0; s_in_w = '0; s_out_ready = 0;
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1'b0);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_out_data", out_data, '0);
        check_eq("rst_s_busy", s_busy, 1'b0);
        rstn = 1'b1;

        // 2x2, K=1: A=[1,2], W=[3,4]
        s_run(1, {8'd2, 8'd1}, {8'd4, 8'd3}, 16'h0, 16'h0, {16'd4, 16'd3}, {16'd8, 16'd6});
        // 2x2 AW=16, K=2, all 255: 130050 wraps to 64514
        s_run(2, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, {16'd64514, 16'd64514}, {16'd64514, 16'd64514});

        fill(2, 8'hFF, 127, 32'hFFFF_FF02);
        start_job(2, 1'b1);
        feed(2, 1'b0, fc);
        collect(2, fc, 1'b1, -1);

        fill(2, 8'hFF, 127, 32'd64770);
        start_job(2, 1'b0);
        feed(2, 1'b0, fc);
        start = 1'b1; k_len = '0;
        @(negedge clk);
        start = 1'b0;
        collect(2, fc, 1'b0, -1);

        fill_mixed(4);
        model(4, 1'b0);
        start_job(4, 1'b0);
        feed(4, 1'b0, fc);
        collect(4, fc, 1'b1, -1);

        start_job(4, 1'b0);
        feed(4, 1'b1, fc);
        collect(4, fc, 1'b0, 1);

        fill(1, 0, 0, 32'd0);
        start_job(0, 1'b0);
        collect(0, 0, 1'b0, -1);

        fill_mixed(4);
        model(4, 1'b0);
        start_job(4, 1'b0);
        feed(4, 1'b0, fc);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check_eq("midrst_in_ready", in_ready, 1'b0);
        check_eq("midrst_out_valid", out_valid, 1'b0);
        check_eq("midrst_busy", busy, 1'b0);
        check_eq("midrst_done", done, 1'b0);
        check_eq("midrst_out_row", out_row, 2'd0);
        check_eq("midrst_out_data", out_data, '0);
        @(negedge clk);
        rstn = 1'b1;
        start_job(4, 1'b0);
        feed(4, 1'b0, fc);
        collect(4, fc, 1'b1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
